// File: rtl/nes_joypad.sv
// NES controller ports $4016/$4017: strobe latch, two 8-bit serial pads with 1-fill, A/B turbo.
module nes_joypad #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [23:0] TURBO_DIV   = 24'd833333,
  parameter logic [7:0]  OPEN_BUS    = 8'h40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [7:0]  joy1,
  input  logic [7:0]  joy2,
  input  logic [3:0]  turbo,
  output logic        strobe
);

  localparam int unsigned PAD_W     = 8;
  localparam int unsigned CNT_W     = 24;
  localparam logic [15:0] ADDR_JOY1 = 16'h4016;
  localparam logic [15:0] ADDR_JOY2 = 16'h4017;
  localparam logic [6:0]  OB_HI     = OPEN_BUS[7:1];
  localparam logic [CNT_W-1:0] CNT_LAST = TURBO_DIV - CNT_W'(1);

  // Synchroniser chains for the pad bytes arriving from the keyboard clock domain
  logic [SYNC_STAGES-1:0][PAD_W-1:0] sync1_q, sync1_d;
  logic [SYNC_STAGES-1:0][PAD_W-1:0] sync2_q, sync2_d;

  // Turbo divider and phase
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // CPU access edge detection
  logic rd_q, rd_d;
  logic wr_q, wr_d;

  // Port state
  logic             strobe_q, strobe_d;
  logic [PAD_W-1:0] sh1_q, sh1_d;
  logic [PAD_W-1:0] sh2_q, sh2_d;
  logic [PAD_W-1:0] dout_q, dout_d;

  // Combinational helpers
  logic [PAD_W-1:0] j1, j2;
  logic [PAD_W-1:0] e1, e2;
  logic             rd_rise, wr_rise;
  logic             unused_din;

  assign unused_din = ^din[7:1];

  // Shift each synchroniser chain by one stage
  always_comb begin
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    for (int i = SYNC_STAGES - 1; i > 0; i--) begin
      sync1_d[i] = sync1_q[i-1];
      sync2_d[i] = sync2_q[i-1];
    end
    sync1_d[0] = joy1;
    sync2_d[0] = joy2;
  end

  assign j1 = sync1_q[SYNC_STAGES-1];
  assign j2 = sync2_q[SYNC_STAGES-1];

  // Turbo counter wraps at TURBO_DIV-1 and toggles the phase on each wrap
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q >= CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Effective buttons: turbo gates A/B with the phase, other buttons pass through
  always_comb begin
    e1    = j1;
    e2    = j2;
    e1[0] = j1[0] & (phase_q | ~turbo[0]);
    e1[1] = j1[1] & (phase_q | ~turbo[1]);
    e2[0] = j2[0] & (phase_q | ~turbo[2]);
    e2[1] = j2[1] & (phase_q | ~turbo[3]);
  end

  // Access edges: one action per rd/wr assertion regardless of hold time
  always_comb begin
    rd_d    = rd;
    wr_d    = wr;
    rd_rise = rd & ~rd_q;
    wr_rise = wr & ~wr_q;
  end

  // Strobe, latch, shift and read-data next state; a write wins over a coincident read
  always_comb begin
    strobe_d = strobe_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    dout_d   = dout_q;

    // Continuous parallel load while the registered strobe is high
    if (strobe_q) begin
      sh1_d = e1;
      sh2_d = e2;
    end

    if (wr_rise) begin
      // $4017 writes are APU frame-counter writes and are not ours
      if (address == ADDR_JOY1) begin
        strobe_d = din[0];
      end
    end else if (rd_rise) begin
      if (address == ADDR_JOY1) begin
        dout_d = {OB_HI, (strobe_q ? e1[0] : sh1_q[0])};
        if (!strobe_q) begin
          sh1_d = {1'b1, sh1_q[PAD_W-1:1]};
        end
      end else if (address == ADDR_JOY2) begin
        dout_d = {OB_HI, (strobe_q ? e2[0] : sh2_q[0])};
        if (!strobe_q) begin
          sh2_d = {1'b1, sh2_q[PAD_W-1:1]};
        end
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      strobe_q <= 1'b0;
      sh1_q    <= 8'hFF;
      sh2_q    <= 8'hFF;
      dout_q   <= 8'h00;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      strobe_q <= strobe_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
      dout_q   <= dout_d;
    end
  end

  assign dout   = dout_q;
  assign strobe = strobe_q;

endmodule
